// File: rtl/seq_slice_adder.sv
// seq_slice_adder: multi-cycle WIDTH-bit a+b+cin computed SLICE bits per cycle with a registered carry
module seq_slice_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N = WIDTH / SLICE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] ar, br, work, wnext;
  logic [WIDTH+SLICE-1:0] t;
  logic [SLICE:0] s;
  logic [CW-1:0] cnt;
  logic carry, last;
  always_comb begin
    s = {1'b0, ar[SLICE-1:0]} + {1'b0, br[SLICE-1:0]} + {{SLICE{1'b0}}, carry};
    t = {s[SLICE-1:0], work};
    wnext = t[WIDTH+SLICE-1:SLICE];
    last = cnt == CW'(N - 1);
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : nxt;
  always_comb nxt = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  always_comb busy = state == RUN;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ar <= '0;
      br <= '0;
      work <= '0;
      carry <= 1'b0;
      cnt <= '0;
      done <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE) begin
      done <= 1'b0;
      if (start) begin
        ar <= a;
        br <= b;
        carry <= cin;
        cnt <= '0;
        work <= '0;
      end
    end else begin
      ar <= ar >> SLICE;
      br <= br >> SLICE;
      carry <= s[SLICE];
      work <= wnext;
      cnt <= cnt + 1'b1;
      done <= last;
      if (last) begin
        sum <= wnext;
        cout <= s[SLICE];
        ovf <= (ar[SLICE-1] == br[SLICE-1]) && (wnext[WIDTH-1] != ar[SLICE-1]);
      end
    end
  end
endmodule
